// File: rtl/timer_pkg.sv
// rtl/timer_pkg.sv - shared constants, conversion FSM states and hex segment encoding for the timer display
package timer_pkg;

    localparam int DEF_IN_W   = 10;
    localparam int DEF_DIGITS = 4;

    typedef enum logic {
        IDLE = 1'b0,
        CONV = 1'b1
    } conv_state_e;

    // Segment bit order {g,f,e,d,c,b,a}, 1 = segment lit.
    typedef logic [6:0] hex_seg_t;

    function automatic hex_seg_t hex_to_seg(input logic [3:0] nibble);
        hex_seg_t seg;
        case (nibble)
            4'h0: seg = 7'h3f;
            4'h1: seg = 7'h06;
            4'h2: seg = 7'h5b;
            4'h3: seg = 7'h4f;
            4'h4: seg = 7'h66;
            4'h5: seg = 7'h6d;
            4'h6: seg = 7'h7d;
            4'h7: seg = 7'h07;
            4'h8: seg = 7'h7f;
            4'h9: seg = 7'h6f;
            4'ha: seg = 7'h77;
            4'hb: seg = 7'h7c;
            4'hc: seg = 7'h39;
            4'hd: seg = 7'h5e;
            4'he: seg = 7'h79;
            default: seg = 7'h71;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// rtl/bin2bcd_seq.sv - serial double-dabble binary to BCD converter, one input bit per cycle
module bin2bcd_seq
    import timer_pkg::*;
#(
    parameter int IN_W   = DEF_IN_W,
    parameter int DIGITS = DEF_DIGITS
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start_i,
    input  logic [IN_W-1:0]     value_i,
    output logic                busy_o,
    output logic                done_o,
    output logic [4*DIGITS-1:0] result_o
);

    localparam int CNT_W = $clog2(IN_W + 1);

    logic [IN_W-1:0]     shift_q;
    logic [4*DIGITS-1:0] work_q;
    logic [4*DIGITS-1:0] adj;
    logic [CNT_W-1:0]    cnt_q;
    logic                busy_q;

    always_comb begin
        adj = work_q;
        for (int i = 0; i < DIGITS; i++) begin
            if (work_q[4*i +: 4] >= 4'd5) begin
                adj[4*i +: 4] = work_q[4*i +: 4] + 4'd3;
            end
        end
    end

    // result_o is the work value after this cycle's shift, so it is final exactly when done_o is high.
    assign result_o = {adj[4*DIGITS-2:0], shift_q[IN_W-1]};
    assign done_o   = busy_q && (cnt_q == CNT_W'(IN_W - 1));
    assign busy_o   = busy_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_q <= '0;
            work_q  <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
        end else if (start_i && !busy_q) begin
            shift_q <= value_i;
            work_q  <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
        end else if (busy_q) begin
            shift_q <= {shift_q[IN_W-2:0], 1'b0};
            work_q  <= result_o;
            cnt_q   <= cnt_q + 1'b1;
            if (done_o) begin
                busy_q <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/hex7seg.sv
// rtl/hex7seg.sv - hex nibble to 7-segment pattern decoder
module hex7seg
    import timer_pkg::*;
(
    input  logic [3:0] nibble_i,
    output logic [6:0] seg_o
);

    assign seg_o = hex_to_seg(nibble_i);

endmodule

// File: rtl/digits_scan_ctrl.sv
// rtl/digits_scan_ctrl.sv - accepts a binary value, converts it to BCD and scans it onto a multiplexed 7-segment display
module digits_scan_ctrl
    import timer_pkg::*;
#(
    parameter int IN_W     = DEF_IN_W,
    parameter int DIGITS   = DEF_DIGITS,
    parameter int SCAN_DIV = 50000,
    parameter int BLANK_LZ = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    input  logic [IN_W-1:0]     in_value,
    output logic                in_ready,
    output logic [4*DIGITS-1:0] bcd,
    output logic [6:0]          seg,
    output logic [DIGITS-1:0]   an
);

    localparam int SCAN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IDX_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    if (10**DIGITS <= 2**IN_W - 1) begin : g_range_chk
        $error("digits_scan_ctrl: DIGITS too small for IN_W");
    end

    conv_state_e         state_q, state_d;
    logic                conv_start;
    logic                conv_busy;
    logic                conv_done;
    logic [4*DIGITS-1:0] conv_result;
    logic [4*DIGITS-1:0] bcd_q;

    assign in_ready = (state_q == IDLE) && !conv_busy;

    always_comb begin
        state_d    = state_q;
        conv_start = 1'b0;
        case (state_q)
            IDLE: begin
                if (in_valid && in_ready) begin
                    conv_start = 1'b1;
                    state_d    = CONV;
                end
            end
            CONV: begin
                if (conv_done) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    bin2bcd_seq #(
        .IN_W   (IN_W),
        .DIGITS (DIGITS)
    ) u_bin2bcd (
        .clk      (clk),
        .rst_n    (rst_n),
        .start_i  (conv_start),
        .value_i  (in_value),
        .busy_o   (conv_busy),
        .done_o   (conv_done),
        .result_o (conv_result)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            bcd_q   <= '0;
        end else begin
            state_q <= state_d;
            if (conv_done) begin
                bcd_q <= conv_result;
            end
        end
    end

    assign bcd = bcd_q;

    logic [SCAN_W-1:0]   scan_cnt_q;
    logic [IDX_W-1:0]    idx_q;
    logic [3:0]          cur_nibble;
    logic [4*DIGITS-1:0] upper_digits;
    logic                blank;
    logic [DIGITS-1:0]   an_d;
    logic [6:0]          seg_d;
    logic [DIGITS-1:0]   an_q;
    logic [6:0]          seg_q;

    // A digit is a leading zero when it and every more significant digit is zero.
    always_comb begin
        cur_nibble   = bcd_q[4*idx_q +: 4];
        upper_digits = bcd_q >> (4 * idx_q);
        blank        = (BLANK_LZ != 0) && (idx_q != '0) && (upper_digits == '0);
        an_d         = '1;
        if (!blank) begin
            an_d[idx_q] = 1'b0;
        end
    end

    hex7seg u_hex (
        .nibble_i (cur_nibble),
        .seg_o    (seg_d)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scan_cnt_q <= '0;
            idx_q      <= '0;
            an_q       <= '1;
            seg_q      <= hex_to_seg(4'h0);
        end else begin
            an_q  <= an_d;
            seg_q <= seg_d;
            if (scan_cnt_q == SCAN_W'(SCAN_DIV - 1)) begin
                scan_cnt_q <= '0;
                idx_q      <= (idx_q == IDX_W'(DIGITS - 1)) ? '0 : idx_q + 1'b1;
            end else begin
                scan_cnt_q <= scan_cnt_q + 1'b1;
            end
        end
    end

    assign an  = an_q;
    assign seg = seg_q;

endmodule

// File: tb/tb_digits_scan_ctrl.sv
// tb/tb_digits_scan_ctrl.sv - directed self-checking bench for digits_scan_ctrl
module tb_digits_scan_ctrl;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic [9:0]  in_value;
    logic        rdy_lz, rdy_nb;
    logic [15:0] bcd_lz, bcd_nb;
    logic [6:0]  seg_lz, seg_nb;
    logic [3:0]  an_lz, an_nb;

    int n_total = 0;
    int n_pass  = 0;

    digits_scan_ctrl #(.IN_W(10), .DIGITS(4), .SCAN_DIV(4), .BLANK_LZ(1)) u_dut_lz (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_value(in_value),
        .in_ready(rdy_lz), .bcd(bcd_lz), .seg(seg_lz), .an(an_lz)
    );

    digits_scan_ctrl #(.IN_W(10), .DIGITS(4), .SCAN_DIV(4), .BLANK_LZ(0)) u_dut_nb (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_value(in_value),
        .in_ready(rdy_nb), .bcd(bcd_nb), .seg(seg_nb), .an(an_nb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [6:0] exp_seg(input int d);
        logic [6:0] tbl [16];
        tbl = '{7'h3f, 7'h06, 7'h5b, 7'h4f, 7'h66, 7'h6d, 7'h7d, 7'h07,
                7'h7f, 7'h6f, 7'h77, 7'h7c, 7'h39, 7'h5e, 7'h79, 7'h71};
        return tbl[d];
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents v for one accept edge; hold_other keeps in_valid high with 999 while converting.
    task automatic convert(input logic [9:0] v, input logic [15:0] prev_bcd,
                           input logic [15:0] exp_bcd, input bit hold_other);
        chk("ready_before_load", rdy_lz, 1);
        in_valid = 1'b1;
        in_value = v;
        tick();
        for (int c = 0; c < 10; c++) begin
            chk("ready_low_conv", {rdy_lz, rdy_nb}, 2'b00);
            chk("bcd_held_conv", bcd_lz, prev_bcd);
            in_valid = hold_other && (c < 9);
            in_value = 10'd999;
            tick();
        end
        in_valid = 1'b0;
        chk("bcd_after_conv", bcd_lz, exp_bcd);
        chk("bcd_after_conv_nb", bcd_nb, exp_bcd);
        chk("ready_after_conv", rdy_lz, 1);
    endtask

    initial begin
        logic [3:0]  prev_an;
        logic [3:0]  exp_an [4];
        int          exp_dig [4];
        int          found;
        int          cnt0;
        logic [3:0]  seen;

        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_value = '0;
        tick(); tick(); tick();
        chk("rst_an", {an_lz, an_nb}, 8'hff);
        chk("rst_ready", {rdy_lz, rdy_nb}, 2'b11);
        chk("rst_bcd", bcd_lz, 16'h0000);
        chk("rst_seg", seg_lz, exp_seg(0));

        rst_n = 1'b1;
        tick();
        chk("first_an_lz", an_lz, 4'b1110);
        chk("first_an_nb", an_nb, 4'b1110);
        chk("first_seg", seg_lz, exp_seg(0));

        convert(10'd1023, 16'h0000, 16'h1023, 1'b0);

        exp_an  = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
        exp_dig = '{3, 2, 0, 1};
        found   = 0;
        for (int t = 0; t < 40 && found == 0; t++) begin
            prev_an = an_lz;
            tick();
            if (an_lz == 4'b1110 && prev_an != 4'b1110) found = 1;
        end
        chk("scan_sync_found", found, 1);
        for (int s = 0; s < 20; s++) begin
            chk("scan_an_lz", an_lz, exp_an[(s / 4) % 4]);
            chk("scan_an_nb", an_nb, exp_an[(s / 4) % 4]);
            chk("scan_seg", seg_lz, exp_seg(exp_dig[(s / 4) % 4]));
            if (s < 19) tick();
        end

        convert(10'd7, 16'h1023, 16'h0007, 1'b0);
        tick();
        cnt0 = 0;
        seen = 4'b0000;
        for (int s = 0; s < 16; s++) begin
            chk("blank_upper_off", an_lz[3:1], 3'b111);
            if (an_lz == 4'b1110) begin
                cnt0++;
                chk("blank_seg7", seg_lz, exp_seg(7));
            end
            seen = seen | ~an_nb;
            tick();
        end
        chk("blank_digit0_slots", cnt0, 4);
        chk("noblank_all_digits", seen, 4'b1111);

        convert(10'd305, 16'h0007, 16'h0305, 1'b1);
        tick();
        chk("drop_no_late_accept", rdy_lz, 1);
        chk("drop_bcd_stable", bcd_lz, 16'h0305);

        in_valid = 1'b1;
        in_value = 10'd512;
        tick();
        in_valid = 1'b0;
        tick(); tick(); tick(); tick();
        chk("midconv_busy", rdy_lz, 0);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_bcd", bcd_lz, 16'h0000);
        chk("midrst_ready", {rdy_lz, rdy_nb}, 2'b11);
        chk("midrst_an", {an_lz, an_nb}, 8'hff);
        chk("midrst_seg", seg_lz, exp_seg(0));
        tick();
        rst_n = 1'b1;
        tick();
        chk("post_rst_an", an_lz, 4'b1110);
        chk("post_rst_bcd", bcd_nb, 16'h0000);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
